move_requester: RTL and testbench
=================================

Name: move_requester

Overview:
- Initiator side of the move-check handshake.
- Accepts move requests from game control and latches the active block's position and rotation.
- Launches one collision check per request on the check interface (run, move code, done, can_move, move_x/move_y). If the check passes, it commits the new x/y/rotation.
- Reports per-move result, block lock (DOWN refused) and game over (APPEAR refused). Sits between the game FSM and the move checker; owns the active-block coordinate registers.

Parameters:
- START_X, 3, column loaded on MOVE_APPEAR (signed, `FIELD_COL_CNT_WIDTH+1 bits)
- START_Y, 0, row loaded on MOVE_APPEAR (signed, `FIELD_ROW_CNT_WIDTH+1 bits)
- CHECK_TIMEOUT, 64, max cycles waiting for check_done_i before abort

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  move request valid
- req_move_i  in  3  `MOVE_* code
- req_ready_o  out  1  request accepted when valid&&ready
- check_run_o  out  1  one-cycle check start pulse
- check_req_move_o  out  3  move code under check, stable from run through done
- check_done_i  in  1  check complete pulse
- check_can_move_i  in  1  check result, valid with done
- check_move_x_i  in  2  signed x delta, valid with done
- check_move_y_i  in  2  signed y delta, valid with done
- block_x_o  out  `FIELD_COL_CNT_WIDTH+1  signed active-block column
- block_y_o  out  `FIELD_ROW_CNT_WIDTH+1  signed active-block row
- block_rotation_o  out  2  active-block rotation
- move_done_o  out  1  one-cycle result pulse
- move_ok_o  out  1  result, valid with move_done_o
- block_locked_o  out  1  one-cycle pulse, DOWN refused
- check_err_o  out  1  one-cycle pulse, timeout abort
- game_over_o  out  1  sticky, APPEAR refused

Behaviour:
- Reset values: all outputs 0; block_x_o=START_X, block_y_o=START_Y; state IDLE; timeout counter 0.
- Reset mid-operation returns to IDLE immediately. A check_done_i arriving later is ignored.
- States: IDLE, RUN, WAIT, RESULT.
- IDLE:
  - req_ready_o = !game_over_o.
  - On valid&&ready: latch req_move_i into check_req_move_o; go to RUN.
  - If the code is MOVE_APPEAR: in the same edge, load block_x/y with START_X/START_Y and rotation with 0.
  - Unknown codes are accepted and treated as a zero move.
- RUN: check_run_o=1 for exactly this cycle; clear timeout counter; go to WAIT. Block registers are held constant from RUN until WAIT exits.
- WAIT:
  - On check_done_i, capture can_move and deltas, then go to RESULT.
  - Otherwise increment the counter. When the counter reaches CHECK_TIMEOUT-1, pulse check_err_o in RESULT with move_ok_o=0 and make no state change.
  - check_done_i seen in IDLE/RUN/RESULT is ignored.
- RESULT (one cycle): move_done_o=1; move_ok_o=captured can_move.
  - If ok: x += sign-extended move_x, y += sign-extended move_y. ROTATE adds rotation+1 mod 4 (3 wraps to 0). APPEAR commits nothing further.
  - If not ok: no register change. DOWN pulses block_locked_o. APPEAR sets game_over_o.
  - Next state IDLE.
- req_ready_o=0 in RUN/WAIT/RESULT, so there is one outstanding check at most.
- Earliest next accept is the cycle after RESULT.
- Latency: accept edge N → run high in cycle N+1 → move_done_o high the cycle after check_done_i is sampled.

Decomposition:
- Shared package/defs: `MOVE_LEFT/RIGHT/DOWN/ROTATE/APPEAR, field width macros, and a state enum typedef.
- No sub-module. The timeout counter and FSM live inline.

Test Plan:
- Reset, then request RIGHT; bench checker returns done=1, can=1, dx=+1 after 18 cycles → run pulse once, x 3→4, move_done_o=1, move_ok_o=1.
- ROTATE three times from rotation 3 (preloaded via 3 prior rotates), all ok → rotation sequence 3→0→1→2; x/y unchanged.
- DOWN with can=0 → move_ok_o=0, block_locked_o pulses once, y unchanged, req_ready_o returns to 1 the following cycle.
- APPEAR after block at (7,12) with can=0 → block at (3,0), rotation 0, game_over_o=1 and stays 1, req_ready_o=0 and further req_valid_i ignored.
- No check_done_i for 64 cycles → check_err_o pulse, move_ok_o=0, no position change. A late done in IDLE causes no move_done_o.
- rst_i asserted in WAIT → next cycle outputs at reset values. Done pulse 2 cycles later ignored. LEFT from x=0 with can=1, dx=-1 → x=-1 (signed arithmetic preserved).

Source files
------------

// File: rtl/move_requester_pkg.sv
// Shared definitions for the move requester: field widths, move codes, FSM states.
package move_requester_pkg;

  localparam int unsigned FIELD_COL_CNT_WIDTH = 4;
  localparam int unsigned FIELD_ROW_CNT_WIDTH = 5;
  localparam int unsigned BLOCK_X_W           = FIELD_COL_CNT_WIDTH + 1;
  localparam int unsigned BLOCK_Y_W           = FIELD_ROW_CNT_WIDTH + 1;
  localparam int unsigned MOVE_W              = 3;

  localparam logic [MOVE_W-1:0] MOVE_LEFT   = 3'd0;
  localparam logic [MOVE_W-1:0] MOVE_RIGHT  = 3'd1;
  localparam logic [MOVE_W-1:0] MOVE_DOWN   = 3'd2;
  localparam logic [MOVE_W-1:0] MOVE_ROTATE = 3'd3;
  localparam logic [MOVE_W-1:0] MOVE_APPEAR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT,
    ST_RESULT
  } req_state_e;

  // Codes whose accepted check result shifts the block by the returned deltas.
  function automatic logic moves_block(input logic [MOVE_W-1:0] code);
    return (code == MOVE_LEFT) || (code == MOVE_RIGHT) ||
           (code == MOVE_DOWN) || (code == MOVE_ROTATE);
  endfunction

endpackage

// File: rtl/move_requester.sv
// Initiator side of the move-check handshake; owns the active-block coordinates.
module move_requester
  import move_requester_pkg::*;
#(
  parameter logic signed [BLOCK_X_W-1:0] START_X       = BLOCK_X_W'(3),
  parameter logic signed [BLOCK_Y_W-1:0] START_Y       = BLOCK_Y_W'(0),
  parameter int unsigned                 CHECK_TIMEOUT = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  input  logic [MOVE_W-1:0]           req_move_i,
  output logic                        req_ready_o,
  output logic                        check_run_o,
  output logic [MOVE_W-1:0]           check_req_move_o,
  input  logic                        check_done_i,
  input  logic                        check_can_move_i,
  input  logic [1:0]                  check_move_x_i,
  input  logic [1:0]                  check_move_y_i,
  output logic signed [BLOCK_X_W-1:0] block_x_o,
  output logic signed [BLOCK_Y_W-1:0] block_y_o,
  output logic [1:0]                  block_rotation_o,
  output logic                        move_done_o,
  output logic                        move_ok_o,
  output logic                        block_locked_o,
  output logic                        check_err_o,
  output logic                        game_over_o
);

  localparam int unsigned CNT_W = (CHECK_TIMEOUT > 2) ? $clog2(CHECK_TIMEOUT) : 1;

  req_state_e                  r_state, w_state_nxt;
  logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
  logic [MOVE_W-1:0]           r_move, w_move_nxt;
  logic signed [BLOCK_X_W-1:0] r_x, w_x_nxt;
  logic signed [BLOCK_Y_W-1:0] r_y, w_y_nxt;
  logic [1:0]                  r_rot, w_rot_nxt;
  logic                        r_ready, w_ready_nxt;
  logic                        r_run, w_run_nxt;
  logic                        r_done, w_done_nxt;
  logic                        r_ok, w_ok_nxt;
  logic                        r_locked, w_locked_nxt;
  logic                        r_err, w_err_nxt;
  logic                        r_go, w_go_nxt;
  logic signed [BLOCK_X_W-1:0] w_dx;
  logic signed [BLOCK_Y_W-1:0] w_dy;

  assign w_dx = {{(BLOCK_X_W-2){check_move_x_i[1]}}, check_move_x_i};
  assign w_dy = {{(BLOCK_Y_W-2){check_move_y_i[1]}}, check_move_y_i};

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_move_nxt   = r_move;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_rot_nxt    = r_rot;
    w_go_nxt     = r_go;
    w_done_nxt   = 1'b0;
    w_ok_nxt     = 1'b0;
    w_locked_nxt = 1'b0;
    w_err_nxt    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (req_valid_i && r_ready) begin
          w_move_nxt  = req_move_i;
          w_state_nxt = ST_RUN;
          if (req_move_i == MOVE_APPEAR) begin
            w_x_nxt   = START_X;
            w_y_nxt   = START_Y;
            w_rot_nxt = 2'd0;
          end
        end
      end
      ST_RUN: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Commit on the WAIT exit edge so coordinates are valid alongside move_done_o.
        if (check_done_i) begin
          w_state_nxt = ST_RESULT;
          w_done_nxt  = 1'b1;
          w_ok_nxt    = check_can_move_i;
          if (check_can_move_i) begin
            if (moves_block(r_move)) begin
              w_x_nxt = r_x + w_dx;
              w_y_nxt = r_y + w_dy;
            end
            if (r_move == MOVE_ROTATE) begin
              w_rot_nxt = r_rot + 2'd1;
            end
          end else begin
            w_locked_nxt = (r_move == MOVE_DOWN);
            if (r_move == MOVE_APPEAR) begin
              w_go_nxt = 1'b1;
            end
          end
        end else if (r_cnt == CNT_W'(CHECK_TIMEOUT - 1)) begin
          w_state_nxt = ST_RESULT;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RESULT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_run_nxt   = (w_state_nxt == ST_RUN);
    w_ready_nxt = (w_state_nxt == ST_IDLE) && !w_go_nxt;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_move   <= '0;
      r_x      <= START_X;
      r_y      <= START_Y;
      r_rot    <= 2'd0;
      r_ready  <= 1'b0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
      r_ok     <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_go     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_move   <= w_move_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_rot    <= w_rot_nxt;
      r_ready  <= w_ready_nxt;
      r_run    <= w_run_nxt;
      r_done   <= w_done_nxt;
      r_ok     <= w_ok_nxt;
      r_locked <= w_locked_nxt;
      r_err    <= w_err_nxt;
      r_go     <= w_go_nxt;
    end
  end

  assign req_ready_o      = r_ready;
  assign check_run_o      = r_run;
  assign check_req_move_o = r_move;
  assign block_x_o        = r_x;
  assign block_y_o        = r_y;
  assign block_rotation_o = r_rot;
  assign move_done_o      = r_done;
  assign move_ok_o        = r_ok;
  assign block_locked_o   = r_locked;
  assign check_err_o      = r_err;
  assign game_over_o      = r_go;

endmodule

// File: tb/tb_move_requester.sv
// Self-checking bench for move_requester with a behavioural game-position model.
module tb_move_requester;
  import move_requester_pkg::*;

  localparam int START_X_TB   = 3;
  localparam int START_Y_TB   = 0;
  localparam int TIMEOUT_TB   = 64;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 req_valid_i = 1'b0;
  logic [MOVE_W-1:0]    req_move_i = '0;
  logic                 req_ready_o;
  logic                 check_run_o;
  logic [MOVE_W-1:0]    check_req_move_o;
  logic                 check_done_i = 1'b0;
  logic                 check_can_move_i = 1'b0;
  logic [1:0]           check_move_x_i = '0;
  logic [1:0]           check_move_y_i = '0;
  logic [BLOCK_X_W-1:0] block_x_o;
  logic [BLOCK_Y_W-1:0] block_y_o;
  logic [1:0]           block_rotation_o;
  logic                 move_done_o;
  logic                 move_ok_o;
  logic                 block_locked_o;
  logic                 check_err_o;
  logic                 game_over_o;

  move_requester #(
    .START_X       (BLOCK_X_W'(START_X_TB)),
    .START_Y       (BLOCK_Y_W'(START_Y_TB)),
    .CHECK_TIMEOUT (TIMEOUT_TB)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_move_i       (req_move_i),
    .req_ready_o      (req_ready_o),
    .check_run_o      (check_run_o),
    .check_req_move_o (check_req_move_o),
    .check_done_i     (check_done_i),
    .check_can_move_i (check_can_move_i),
    .check_move_x_i   (check_move_x_i),
    .check_move_y_i   (check_move_y_i),
    .block_x_o        (block_x_o),
    .block_y_o        (block_y_o),
    .block_rotation_o (block_rotation_o),
    .move_done_o      (move_done_o),
    .move_ok_o        (move_ok_o),
    .block_locked_o   (block_locked_o),
    .check_err_o      (check_err_o),
    .game_over_o      (game_over_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference game state
  int mx, my, mrot;
  bit mgo;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_pos(input string tag);
    chk({tag, "_x"},   $signed(block_x_o), mx);
    chk({tag, "_y"},   $signed(block_y_o), my);
    chk({tag, "_rot"}, int'(block_rotation_o), mrot);
  endtask

  task automatic model_reset();
    mx = START_X_TB; my = START_Y_TB; mrot = 0; mgo = 0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    model_reset();
    chk("rst_ready", int'(req_ready_o), 0);
    chk("rst_run",   int'(check_run_o), 0);
    chk("rst_done",  int'(move_done_o), 0);
    chk("rst_go",    int'(game_over_o), 0);
    chk_pos("rst");
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready_after", int'(req_ready_o), 1);
  endtask

  // One full request: accept, optional spurious done in RUN, checker reply (or timeout), result.
  task automatic do_move(input logic [MOVE_W-1:0] code, input bit can, input int dx,
                         input int dy, input int dly, input bit tmo, input bit spurious);
    int runs;
    int cyc;
    int e_ok, e_lock, e_err;
    cyc = 0;
    while (!req_ready_o && cyc < 8) begin @(negedge clk_i); cyc++; end
    chk("req_ready", int'(req_ready_o), 1);
    req_valid_i = 1'b1;
    req_move_i  = code;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_move_i  = MOVE_W'($urandom);
    runs = int'(check_run_o);
    chk("run_cmd", int'(check_req_move_o), int'(code));
    if (code == MOVE_APPEAR) begin
      mx = START_X_TB; my = START_Y_TB; mrot = 0;
    end
    chk_pos("accept");
    if (spurious) begin
      check_done_i = 1'b1; check_can_move_i = 1'b1; check_move_x_i = 2'b01; check_move_y_i = 2'b01;
    end
    @(negedge clk_i);
    check_done_i = 1'b0;
    runs += int'(check_run_o);
    if (tmo) begin
      cyc = 1;
      while (!move_done_o && cyc < 200) begin
        @(negedge clk_i);
        runs += int'(check_run_o);
        cyc++;
      end
      chk("timeout_latency", cyc, TIMEOUT_TB + 1);
      e_ok = 0; e_lock = 0; e_err = 1;
    end else begin
      repeat (dly) begin
        @(negedge clk_i);
        runs += int'(check_run_o);
        chk("wait_hold_x", $signed(block_x_o), mx);
      end
      check_done_i     = 1'b1;
      check_can_move_i = can;
      check_move_x_i   = 2'(dx);
      check_move_y_i   = 2'(dy);
      @(negedge clk_i);
      check_done_i     = 1'b0;
      check_can_move_i = 1'($urandom);
      check_move_x_i   = 2'($urandom);
      check_move_y_i   = 2'($urandom);
      e_ok = int'(can); e_err = 0;
      e_lock = (!can && code == MOVE_DOWN) ? 1 : 0;
      if (can && (code == MOVE_LEFT || code == MOVE_RIGHT || code == MOVE_DOWN || code == MOVE_ROTATE)) begin
        mx += dx; my += dy;
        if (code == MOVE_ROTATE) mrot = (mrot + 1) % 4;
      end
      if (!can && code == MOVE_APPEAR) mgo = 1;
    end
    chk("run_pulses",  runs, 1);
    chk("move_done",   int'(move_done_o), 1);
    chk("move_ok",     int'(move_ok_o), e_ok);
    chk("locked",      int'(block_locked_o), e_lock);
    chk("check_err",   int'(check_err_o), e_err);
    chk("game_over",   int'(game_over_o), int'(mgo));
    chk_pos("result");
    @(negedge clk_i);
    chk("done_clear",  int'(move_done_o), 0);
    chk("locked_clear", int'(block_locked_o), 0);
    chk("ready_after", int'(req_ready_o), mgo ? 0 : 1);
  endtask

  initial begin
    int runs;
    logic [MOVE_W-1:0] code;
    int dx, dy;
    model_reset();

    // Reset values
    repeat (3) @(negedge clk_i);
    chk("reset_ready", int'(req_ready_o), 0);
    chk("reset_done",  int'(move_done_o), 0);
    chk("reset_err",   int'(check_err_o), 0);
    chk_pos("reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_ready", int'(req_ready_o), 1);

    // RIGHT with a slow checker
    do_move(MOVE_RIGHT, 1'b1, 1, 0, 18, 1'b0, 1'b0);
    chk("right_x", $signed(block_x_o), 4);

    // Rotation wrap 3 -> 0 -> 1 -> 2
    for (int i = 0; i < 6; i++) do_move(MOVE_ROTATE, 1'b1, 0, 0, i % 3, 1'b0, 1'b0);
    chk("rot_final", int'(block_rotation_o), 2);

    // Refused DOWN locks the block
    do_move(MOVE_DOWN, 1'b0, 0, 1, 2, 1'b0, 1'b1);

    // Walk to (7,12) then refused APPEAR -> game over
    for (int i = 0; i < 3; i++)  do_move(MOVE_RIGHT, 1'b1, 1, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) do_move(MOVE_DOWN, 1'b1, 0, 1, 0, 1'b0, 1'b0);
    chk("walk_x", $signed(block_x_o), 7);
    chk("walk_y", $signed(block_y_o), 12);
    do_move(MOVE_APPEAR, 1'b0, 0, 0, 3, 1'b0, 1'b0);
    chk("appear_x", $signed(block_x_o), 3);
    chk("appear_y", $signed(block_y_o), 0);
    runs = 0;
    req_valid_i = 1'b1; req_move_i = MOVE_LEFT;
    repeat (10) begin @(negedge clk_i); runs += int'(check_run_o); end
    req_valid_i = 1'b0;
    chk("go_ignored_runs", runs, 0);
    chk("go_sticky", int'(game_over_o), 1);
    chk("go_ready", int'(req_ready_o), 0);
    do_reset();

    // Timeout then a late done in IDLE
    do_move(MOVE_RIGHT, 1'b1, 1, 0, 0, 1'b1, 1'b0);
    check_done_i = 1'b1; check_can_move_i = 1'b1; check_move_x_i = 2'b01;
    @(negedge clk_i);
    check_done_i = 1'b0;
    chk("late_done_a", int'(move_done_o), 0);
    @(negedge clk_i);
    chk("late_done_b", int'(move_done_o), 0);
    chk_pos("late_done");

    // Reset while waiting for the checker
    do_move(MOVE_DOWN, 1'b1, 0, 1, 1, 1'b0, 1'b0);
    req_valid_i = 1'b1; req_move_i = MOVE_RIGHT;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    model_reset();
    chk("wrst_ready", int'(req_ready_o), 0);
    chk("wrst_run",   int'(check_run_o), 0);
    chk("wrst_done",  int'(move_done_o), 0);
    chk_pos("wrst");
    rst_i = 1'b0;
    @(negedge clk_i);
    check_done_i = 1'b1; check_can_move_i = 1'b1; check_move_x_i = 2'b01; check_move_y_i = 2'b01;
    @(negedge clk_i);
    check_done_i = 1'b0;
    chk("wrst_late_a", int'(move_done_o), 0);
    @(negedge clk_i);
    chk("wrst_late_b", int'(move_done_o), 0);
    chk_pos("wrst_after");

    // LEFT past column 0 keeps signed value
    for (int i = 0; i < 4; i++) do_move(MOVE_LEFT, 1'b1, -1, 0, 1, 1'b0, 1'b0);
    chk("left_neg_x", $signed(block_x_o), -1);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      code = MOVE_W'($urandom_range(0, 7));
      dx = $urandom_range(0, 2) - 1;
      dy = $urandom_range(0, 2) - 1;
      if (mx >= 10) dx = -1;
      if (mx <= -8) dx = 1;
      if (my >= 25) dy = -1;
      if (my <= -25) dy = 1;
      do_move(code, 1'($urandom), dx, dy, $urandom_range(0, 5),
              ($urandom_range(0, 14) == 0), 1'($urandom));
      if (mgo) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
